// File: rtl/risc8_pkg.sv
// Shared definitions for the risc8 write-back path: source encodings,
// pointer register indices and the byte-set overlap test.
package risc8_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_MEM  = 2'd2,
    SRC_PTR  = 2'd3
  } wb_src_e;

  localparam logic [5:0] REG_X = 6'd26;
  localparam logic [5:0] REG_Y = 6'd28;
  localparam logic [5:0] REG_Z = 6'd30;

  // A word write covers {d&~1, d|1}; a byte write covers {d}.
  // If either side is a word, the sets meet exactly when the pair index matches.
  function automatic logic wb_overlap(input logic [5:0] a_d, input logic a_word,
                                      input logic [5:0] b_d, input logic b_word);
    if (a_word || b_word) return a_d[5:1] == b_d[5:1];
    return a_d == b_d;
  endfunction

endpackage

// File: rtl/wb_hold_buf.sv
// One-entry write-back hold buffer with valid/ready capture and an aging
// counter that saturates at MAX_WAIT while the entry waits for a grant.
module wb_hold_buf
  import risc8_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_d,
  input  logic        in_word,
  input  logic [15:0] in_data,
  input  logic        grant,
  output logic        full,
  output logic [5:0]  d,
  output logic        word,
  output logic [15:0] data,
  output logic        aged
);

  localparam int unsigned AW = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [AW-1:0] AGE_MAX = AW'(MAX_WAIT);

  logic          full_q, full_d;
  logic [5:0]    d_q, d_d;
  logic          word_q, word_d;
  logic [15:0]   data_q, data_d;
  logic [AW-1:0] age_q, age_d;

  // Capture, release and aging of the single entry.
  always_comb begin
    in_ready = !full_q || grant;
    full_d   = full_q;
    d_d      = d_q;
    word_d   = word_q;
    data_d   = data_q;
    age_d    = age_q;
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      d_d    = in_d;
      word_d = in_word;
      data_d = in_data;
      age_d  = '0;
    end else if (grant) begin
      full_d = 1'b0;
      age_d  = '0;
    end else if (full_q && (age_q != AGE_MAX)) begin
      age_d = age_q + 1'b1;
    end
  end

  // Entry state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      full_q <= 1'b0;
      d_q    <= '0;
      word_q <= 1'b0;
      data_q <= '0;
      age_q  <= '0;
    end else begin
      full_q <= full_d;
      d_q    <= d_d;
      word_q <= word_d;
      data_q <= data_d;
      age_q  <= age_d;
    end
  end

  assign full = full_q;
  assign d    = d_q;
  assign word = word_q;
  assign data = data_q;
  assign aged = full_q && (age_q >= AGE_MAX);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port. ALU requests
// go straight to arbitration; load and pointer write-backs are held in
// one-entry buffers that gain priority when aged or when they would be
// overtaken by an overlapping ALU write.
module regfile_wb_arbiter
  import risc8_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [5:0]  alu_d,
  input  logic        alu_word,
  input  logic [15:0] alu_data,
  output logic        alu_stall,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [5:0]  mem_d,
  input  logic        mem_word,
  input  logic [15:0] mem_data,
  input  logic        ptr_valid,
  output logic        ptr_ready,
  input  logic [5:0]  ptr_d,
  input  logic [15:0] ptr_data,
  input  logic [5:0]  qa,
  input  logic [5:0]  qb,
  input  logic        qa_word,
  output logic        hazard,
  output logic        write,
  output logic        write_word,
  output logic [5:0]  d,
  output logic [15:0] Rd
);

  logic        mbuf_full, mbuf_word, mbuf_aged, mbuf_grant;
  logic [5:0]  mbuf_d;
  logic [15:0] mbuf_data;
  logic        pbuf_full, pbuf_word, pbuf_aged, pbuf_grant;
  logic [5:0]  pbuf_d;
  logic [15:0] pbuf_data;

  wb_src_e     grant_src;
  logic        mbuf_prom, pbuf_prom, rr_mem;
  logic        sel_word;
  logic [5:0]  sel_d;
  logic [15:0] sel_data;

  logic        last_ptr_q, last_ptr_d;
  logic        write_q, write_d;
  logic        write_word_q, write_word_d;
  logic [5:0]  d_q, d_d;
  logic [15:0] rd_q, rd_d;

  wb_hold_buf #(.MAX_WAIT(MAX_WAIT)) u_mbuf (
    .clk(clk), .reset(reset),
    .in_valid(mem_valid), .in_ready(mem_ready),
    .in_d(mem_d), .in_word(mem_word), .in_data(mem_data),
    .grant(mbuf_grant),
    .full(mbuf_full), .d(mbuf_d), .word(mbuf_word), .data(mbuf_data), .aged(mbuf_aged)
  );

  wb_hold_buf #(.MAX_WAIT(MAX_WAIT)) u_pbuf (
    .clk(clk), .reset(reset),
    .in_valid(ptr_valid), .in_ready(ptr_ready),
    .in_d(ptr_d), .in_word(1'b1), .in_data(ptr_data),
    .grant(pbuf_grant),
    .full(pbuf_full), .d(pbuf_d), .word(pbuf_word), .data(pbuf_data), .aged(pbuf_aged)
  );

  // Grant selection: promoted buffers, then ALU, then buffers round-robin.
  always_comb begin
    mbuf_prom = mbuf_full && (mbuf_aged ||
                (alu_valid && wb_overlap(mbuf_d, mbuf_word, alu_d, alu_word)));
    pbuf_prom = pbuf_full && (pbuf_aged ||
                (alu_valid && wb_overlap(pbuf_d, pbuf_word, alu_d, alu_word)));
    rr_mem    = last_ptr_q;
    grant_src = SRC_NONE;
    if (mbuf_prom && pbuf_prom)      grant_src = rr_mem ? SRC_MEM : SRC_PTR;
    else if (mbuf_prom)              grant_src = SRC_MEM;
    else if (pbuf_prom)              grant_src = SRC_PTR;
    else if (alu_valid)              grant_src = SRC_ALU;
    else if (mbuf_full && pbuf_full) grant_src = rr_mem ? SRC_MEM : SRC_PTR;
    else if (mbuf_full)              grant_src = SRC_MEM;
    else if (pbuf_full)              grant_src = SRC_PTR;

    mbuf_grant = (grant_src == SRC_MEM);
    pbuf_grant = (grant_src == SRC_PTR);
    alu_stall  = alu_valid && (grant_src != SRC_ALU);

    last_ptr_d = last_ptr_q;
    if (mbuf_grant) last_ptr_d = 1'b0;
    if (pbuf_grant) last_ptr_d = 1'b1;
  end

  // Winner's payload and next write-port contents; word writes are forced aligned.
  always_comb begin
    sel_word = 1'b0;
    sel_d    = '0;
    sel_data = '0;
    case (grant_src)
      SRC_ALU: begin sel_word = alu_word;  sel_d = alu_d;  sel_data = alu_data;  end
      SRC_MEM: begin sel_word = mbuf_word; sel_d = mbuf_d; sel_data = mbuf_data; end
      SRC_PTR: begin sel_word = pbuf_word; sel_d = pbuf_d; sel_data = pbuf_data; end
      default: ;
    endcase
    write_d      = (grant_src != SRC_NONE);
    write_word_d = sel_word;
    d_d          = sel_word ? {sel_d[5:1], 1'b0} : sel_d;
    rd_d         = sel_data;
  end

  // Registered write port and round-robin state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      write_q      <= 1'b0;
      write_word_q <= 1'b0;
      d_q          <= '0;
      rd_q         <= '0;
      last_ptr_q   <= 1'b1;
    end else begin
      write_q      <= write_d;
      write_word_q <= write_word_d;
      d_q          <= d_d;
      rd_q         <= rd_d;
      last_ptr_q   <= last_ptr_d;
    end
  end

  // Read-after-write hazard against buffered writes and the in-flight port write.
  always_comb begin
    hazard = (mbuf_full && wb_overlap(qa, qa_word, mbuf_d, mbuf_word)) ||
             (pbuf_full && wb_overlap(qa, qa_word, pbuf_d, pbuf_word)) ||
             (write_q   && wb_overlap(qa, qa_word, d_q, write_word_q)) ||
             (mbuf_full && wb_overlap(qb, 1'b0, mbuf_d, mbuf_word)) ||
             (pbuf_full && wb_overlap(qb, 1'b0, pbuf_d, pbuf_word)) ||
             (write_q   && wb_overlap(qb, 1'b0, d_q, write_word_q));
  end

  assign write      = write_q;
  assign write_word = write_word_q;
  assign d          = d_q;
  assign Rd         = rd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: ALU-only vector table followed by
// hand-written multi-cycle sequences for buffering, aging, ordering and hazards.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, alu_word, alu_stall;
  logic [5:0]  alu_d;
  logic [15:0] alu_data;
  logic        mem_valid, mem_ready, mem_word;
  logic [5:0]  mem_d;
  logic [15:0] mem_data;
  logic        ptr_valid, ptr_ready;
  logic [5:0]  ptr_d;
  logic [15:0] ptr_data;
  logic [5:0]  qa, qb;
  logic        qa_word, hazard;
  logic        write, write_word;
  logic [5:0]  d;
  logic [15:0] Rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_WAIT(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_d(alu_d), .alu_word(alu_word), .alu_data(alu_data),
    .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_d(mem_d), .mem_word(mem_word),
    .mem_data(mem_data),
    .ptr_valid(ptr_valid), .ptr_ready(ptr_ready), .ptr_d(ptr_d), .ptr_data(ptr_data),
    .qa(qa), .qb(qb), .qa_word(qa_word), .hazard(hazard),
    .write(write), .write_word(write_word), .d(d), .Rd(Rd)
  );

  typedef struct {
    logic        alu_v;
    logic [5:0]  alu_d;
    logic        alu_w;
    logic [15:0] alu_data;
    logic [5:0]  qa;
    logic        qa_w;
    logic [5:0]  qb;
    logic        e_write;
    logic        e_ww;
    logic [5:0]  e_d;
    logic [15:0] e_rd;
    logic        e_haz;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_port(input string nm, input logic e_w, input logic e_ww,
                          input logic [5:0] e_d, input logic [15:0] e_rd);
    chk({nm, "_write"}, 16'(write), 16'(e_w));
    chk({nm, "_word"},  16'(write_word), 16'(e_ww));
    chk({nm, "_d"},     16'(d), 16'(e_d));
    chk({nm, "_rd"},    Rd, e_rd);
  endtask

  initial begin
    vecs[0] = '{1'b1, 6'd5,  1'b0, 16'h00AA, 6'd5,  1'b0, 6'd0,  1'b1, 1'b0, 6'd5,  16'h00AA, 1'b1};
    vecs[1] = '{1'b1, 6'd10, 1'b1, 16'h1234, 6'd11, 1'b0, 6'd0,  1'b1, 1'b1, 6'd10, 16'h1234, 1'b1};
    vecs[2] = '{1'b1, 6'd7,  1'b1, 16'hBEEF, 6'd8,  1'b1, 6'd3,  1'b1, 1'b1, 6'd6,  16'hBEEF, 1'b0};
    vecs[3] = '{1'b0, 6'd0,  1'b0, 16'h0000, 6'd6,  1'b0, 6'd6,  1'b0, 1'b0, 6'd0,  16'h0000, 1'b0};
    vecs[4] = '{1'b1, 6'd0,  1'b0, 16'h00FF, 6'd1,  1'b1, 6'd0,  1'b1, 1'b0, 6'd0,  16'h00FF, 1'b1};
    vecs[5] = '{1'b1, 6'd63, 1'b0, 16'h0001, 6'd0,  1'b0, 6'd63, 1'b1, 1'b0, 6'd63, 16'h0001, 1'b1};

    reset = 1'b0;
    alu_valid = 1'b0; alu_d = '0; alu_word = 1'b0; alu_data = '0;
    mem_valid = 1'b0; mem_d = '0; mem_word = 1'b0; mem_data = '0;
    ptr_valid = 1'b0; ptr_d = '0; ptr_data = '0;
    qa = '0; qb = '0; qa_word = 1'b0;

    // Reset then idle.
    tick();
    tick();
    chk_port("rst", 1'b0, 1'b0, 6'd0, 16'h0000);
    reset = 1'b1;
    #1;
    chk("rst_mem_ready", 16'(mem_ready), 16'd1);
    chk("rst_ptr_ready", 16'(ptr_ready), 16'd1);
    chk("rst_hazard",    16'(hazard),    16'd0);
    chk("rst_stall",     16'(alu_stall), 16'd0);

    // ALU-only vectors: one-cycle latency, word alignment, port hazard.
    for (int i = 0; i < 6; i++) begin
      alu_valid = vecs[i].alu_v;   alu_d = vecs[i].alu_d;
      alu_word  = vecs[i].alu_w;   alu_data = vecs[i].alu_data;
      qa = vecs[i].qa; qa_word = vecs[i].qa_w; qb = vecs[i].qb;
      #1;
      chk($sformatf("v%0d_stall", i), 16'(alu_stall), 16'd0);
      tick();
      chk_port($sformatf("v%0d", i), vecs[i].e_write, vecs[i].e_ww, vecs[i].e_d, vecs[i].e_rd);
      chk($sformatf("v%0d_hazard", i), 16'(hazard), 16'(vecs[i].e_haz));
    end
    alu_valid = 1'b0;
    qa = 6'd60; qb = 6'd60; qa_word = 1'b0;

    // Simultaneous mem/ptr capture; mem wins first tie, ptr wins the next.
    mem_valid = 1'b1; mem_d = 6'd16; mem_word = 1'b0; mem_data = 16'h0011;
    ptr_valid = 1'b1; ptr_d = 6'd26; ptr_data = 16'hBEEF;
    #1;
    chk("tie_mem_ready0", 16'(mem_ready), 16'd1);
    chk("tie_ptr_ready0", 16'(ptr_ready), 16'd1);
    tick();
    mem_d = 6'd17; mem_data = 16'h0022; ptr_valid = 1'b0;
    #1;
    chk("tie_mem_ready1", 16'(mem_ready), 16'd1);
    chk("tie_idle_write", 16'(write), 16'd0);
    tick();
    mem_valid = 1'b0;
    chk_port("tie_w1", 1'b1, 1'b0, 6'd16, 16'h0011);
    #1;
    chk("tie_mem_ready2", 16'(mem_ready), 16'd0);
    chk("tie_ptr_ready2", 16'(ptr_ready), 16'd1);
    tick();
    chk_port("tie_w2", 1'b1, 1'b1, 6'd26, 16'hBEEF);
    tick();
    chk_port("tie_w3", 1'b1, 1'b0, 6'd17, 16'h0022);
    tick();
    chk("tie_w4_write", 16'(write), 16'd0);

    // Aging: ALU wins three times, then the aged mem entry is promoted.
    mem_valid = 1'b1; mem_d = 6'd40; mem_word = 1'b0; mem_data = 16'h0040;
    tick();
    mem_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      alu_valid = 1'b1; alu_d = 6'(k); alu_word = 1'b0; alu_data = 16'h0100 + 16'(k);
      #1;
      chk($sformatf("age_stall%0d", k), 16'(alu_stall), (k == 4) ? 16'd1 : 16'd0);
      tick();
      if (k < 4) chk_port($sformatf("age_alu%0d", k), 1'b1, 1'b0, 6'(k), 16'h0100 + 16'(k));
    end
    chk_port("age_mem", 1'b1, 1'b0, 6'd40, 16'h0040);
    chk("age_stall_after", 16'(alu_stall), 16'd0);
    tick();
    alu_valid = 1'b0;
    chk_port("age_alu4", 1'b1, 1'b0, 6'd4, 16'h0104);

    // Overlap promotion: buffered word 26 goes before ALU byte 27.
    ptr_valid = 1'b1; ptr_d = 6'd26; ptr_data = 16'h1A1A;
    tick();
    ptr_valid = 1'b0;
    alu_valid = 1'b1; alu_d = 6'd27; alu_word = 1'b0; alu_data = 16'h2727;
    #1;
    chk("ovl_stall", 16'(alu_stall), 16'd1);
    chk("ovl_ptr_ready", 16'(ptr_ready), 16'd1);
    tick();
    chk_port("ovl_w1", 1'b1, 1'b1, 6'd26, 16'h1A1A);
    chk("ovl_stall2", 16'(alu_stall), 16'd0);
    tick();
    alu_valid = 1'b0;
    chk_port("ovl_w2", 1'b1, 1'b0, 6'd27, 16'h2727);

    // Hazard against pbuf and then against the one-cycle-late port write.
    ptr_valid = 1'b1; ptr_d = 6'd30; ptr_data = 16'h3030;
    tick();
    ptr_valid = 1'b0;
    qa = 6'd31; qa_word = 1'b0; qb = 6'd0;
    #1;
    chk("haz_pbuf31", 16'(hazard), 16'd1);
    qa = 6'd29;
    #1;
    chk("haz_pbuf29", 16'(hazard), 16'd0);
    qa = 6'd31;
    tick();
    chk_port("haz_w", 1'b1, 1'b1, 6'd30, 16'h3030);
    chk("haz_port31", 16'(hazard), 16'd1);
    tick();
    chk("haz_clear31", 16'(hazard), 16'd0);

    // Reset mid-operation drops a buffered load.
    qa = 6'd50;
    mem_valid = 1'b1; mem_d = 6'd50; mem_word = 1'b0; mem_data = 16'h5050;
    alu_valid = 1'b1; alu_d = 6'd20; alu_word = 1'b1; alu_data = 16'h2020;
    tick();
    mem_valid = 1'b0; alu_valid = 1'b0; reset = 1'b0;
    #1;
    chk("mrst_haz_before", 16'(hazard), 16'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("mrst_mem_ready", 16'(mem_ready), 16'd1);
    chk("mrst_hazard",    16'(hazard),    16'd0);
    chk("mrst_write",     16'(write),     16'd0);
    tick();
    chk("mrst_dropped",   16'(write),     16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the single-write-port register file. Three sources share the port: ALU results, memory load data, and pointer (X/Y/Z) post-inc/pre-dec updates. Memory and pointer sources each get a one-entry hold buffer. An aging counter bounds their wait, and a byte-granular hazard output lets decode stall on registers with pending writes. The outputs drive the register file's `write`/`write_word`/`d`/`Rd` inputs directly.

## Interface
- `MAX_WAIT`, default 3: cycles a buffered entry may lose to the ALU before it is promoted above the ALU.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `alu_valid` in 1, `alu_d` in 6, `alu_word` in 1, `alu_data` in 16: ALU write request. Holds while `alu_stall`=1.
- `alu_stall` out 1: ALU request not granted this cycle; the core freezes.
- `mem_valid` in 1, `mem_ready` out 1, `mem_d` in 6, `mem_word` in 1, `mem_data` in 16: load write-back, valid/ready.
- `ptr_valid` in 1, `ptr_ready` out 1, `ptr_d` in 6, `ptr_data` in 16: pointer write-back. Always a word write.
- `qa` in 6, `qb` in 6: decode read addresses. `qa` is checked as a word if `qa_word`=1.
- `qa_word` in 1: treat `qa` as a word address.
- `hazard` out 1: a pending write overlaps `qa` or `qb`. Combinational.
- `write` out 1, `write_word` out 1, `d` out 6, `Rd` out 16: register-file write port. Registered.

## Operation
- Byte set of a write: word = {d&~1, d|1}; byte = {d}. Two writes overlap if their byte sets intersect.
- Buffers `mbuf` and `pbuf` each hold {full, d, word, data, age}.
  - `X_ready` = !full || granted-this-cycle.
  - Capture happens on the edge where `X_valid && X_ready`.
- Eligible candidates each cycle: ALU (if `alu_valid`), `mbuf` (if full), `pbuf` (if full).
- Priority, highest first:
  1. A buffer whose age ≥ `MAX_WAIT`, or whose byte set overlaps the valid ALU request. Promoted; this preserves write order.
  2. The ALU.
  3. Buffers, round-robin. The last-grant flag resets to "ptr", so `mbuf` wins the first tie.
  - If both buffers are promoted, the round-robin chooses between them.
- Exactly one grant per cycle. The winner is registered onto the write port on the next edge.
- `alu_stall` = `alu_valid` && ALU not granted.
- Age increments each cycle a full buffer is not granted and saturates at `MAX_WAIT`. It clears on grant or capture.
- `hazard` checks `qa`/`qb` against `mbuf`, `pbuf`, and the registered write port (the register file exposes writes one cycle late). The pending ALU request is excluded.
- Unaligned word `d` (d[0]=1) is illegal. It is written with `d[0]` forced to 0.

## Timing
- Reset (`reset`=0 at an edge): `write`=0, `write_word`=0, `d`=0, `Rd`=0. Buffers and ages are cleared and the last-grant flag is set to ptr.
  - `mem_ready`/`ptr_ready` read 1 on the first cycle after reset.
  - `alu_stall` and `hazard` read 0 while buffers are empty and no ALU request is present.
  - Reset mid-operation drops buffered writes silently.
- ALU latency: request in cycle N, granted → `write`=1 in cycle N+1.
- Mem/ptr latency: accepted at edge N → eligible in cycle N+1 → earliest `write` in cycle N+2.
- Throughput is one write per cycle. A buffer sustains one accept per cycle when it is granted each cycle.
- Worst-case buffered wait is `MAX_WAIT`+1 cycles of eligibility (+1 if both buffers are promoted together).
- `write` is deasserted in any cycle following a cycle with no grant.
- `hazard` and the ready signals are combinational from state and inputs. No combinational path runs from `mem_valid`/`ptr_valid` to `alu_stall`.

## Structure
- Shared package `risc8_pkg`: source-encoding constants (SRC_ALU, SRC_MEM, SRC_PTR), the pointer register indices (X=26, Y=28, Z=30), and the byte-set overlap function.
- One sub-module, `wb_hold_buf`: a one-entry buffer with valid/ready capture, age counter and release. Instantiated twice.
- The arbiter, the overlap checks and the output register live in the top module.

## Test plan
- Reset then idle, `reset`=0 for 2 cycles: outputs 0, `mem_ready`=`ptr_ready`=1, `hazard`=0.
- ALU byte write d=5, data=0x00AA in cycle 0: cycle 1 shows `write`=1, `write_word`=0, d=5, Rd=0x00AA; `alu_stall`=0.
- mem d=16/0x0011 and ptr d=26/0xBEEF both accepted at the same edge, ALU idle: mem writes first, ptr one cycle later; then ptr wins the next tie.
- Continuous ALU requests with `mbuf` full, `MAX_WAIT`=3: ALU wins 3 cycles. On the 4th, mem is granted with `alu_stall`=1 for that cycle.
- `pbuf` holds word d=26 and ALU requests byte d=27: ptr is granted first with `alu_stall`=1; ALU writes d=27 the next cycle. Final port order: 26w, 27b.
- `pbuf` full, d=30 word, `qa`=31: `hazard`=1. `qa`=29: `hazard`=0. After the ptr write completes plus one cycle, `qa`=31 gives `hazard`=0.
